fire_ofm_writer: RTL and testbench

- Receiving end of a fire layer's output interface.
- Captures the DSP_NO-wide ofm vector on each layer sample pulse and serializes it, LANES channels per cycle, into the feature-map RAM write port.
- Counts WOUT**2 output pixels, then returns the single-cycle ram_feedback pulse to the layer, which latches it.
- Sits between a layer core (e.g. an expand1x1 stage) and the activation RAM read by the next layer.

---
 rtl/fire_ofm_writer.sv | 203 ++++++++++++++++++++
 tb/tb_fire_ofm_writer.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fire_ofm_writer.sv
// fire_ofm_writer: receiving end of a fire layer's output interface.
// Captures the DSP_NO-wide ofm vector on layer_sample and writes it out in
// LANES-wide beats to the feature-map RAM. After WOUT**2 pixels it gives the
// layer a single ram_feedback pulse, then parks in DONE until reset.
// Optional feature: define OFM_WR_CHKSUM_EN to add the chksum output, a
// running modulo-2**WIDTH sum of every lane word written.
module fire_ofm_writer #(
  parameter int DSP_NO = 368,
  parameter int WIDTH  = 16,
  parameter int WOUT   = 8,
  parameter int LANES  = 4,
  parameter int ADDR_W = $clog2(WOUT * WOUT * DSP_NO / LANES)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     layer_sample,
  input  logic [WIDTH-1:0]         ofm [DSP_NO],
  output logic                     wr_en,
  output logic [ADDR_W-1:0]        wr_addr,
  output logic [LANES*WIDTH-1:0]   wr_data,
  output logic                     ram_feedback,
  output logic                     busy,
  output logic                     overrun
`ifdef OFM_WR_CHKSUM_EN
  ,
  output logic [WIDTH-1:0]         chksum
`endif
);

  localparam int BEATS  = DSP_NO / LANES;
  localparam int NPIX   = WOUT * WOUT;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int PIX_W  = $clog2(NPIX + 1);
  localparam int CH_W   = (DSP_NO > 1) ? $clog2(DSP_NO) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                   state_q, state_d;
  logic [BEAT_W-1:0]        beat_q, beat_d;
  logic [PIX_W-1:0]         pixel_q, pixel_d;
  logic [ADDR_W-1:0]        addr_q, addr_d;
  logic [WIDTH-1:0]         shadow_q [DSP_NO];
  logic [WIDTH-1:0]         shadow_d [DSP_NO];
  logic                     wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]        wr_addr_q, wr_addr_d;
  logic [LANES*WIDTH-1:0]   wr_data_q, wr_data_d;
  logic                     last_q, last_d;
  logic                     fb_q, fb_d;
  logic                     overrun_q, overrun_d;

  logic                     beat_last;
  logic                     final_pix;
  logic                     accept;
  logic [CH_W-1:0]          ch_base;
  logic [LANES*WIDTH-1:0]   lane_bus;

  assign beat_last = (beat_q == BEAT_W'(BEATS - 1));
  assign final_pix = (pixel_q == PIX_W'(NPIX - 1));
  // A sample lands when idle, or exactly on the last beat of a non-final
  // pixel so consecutive pixels stream without a bubble.
  assign accept    = layer_sample &&
                     ((state_q == IDLE) ||
                      ((state_q == BURST) && beat_last && !final_pix));

  // Channel gather: lane gi of the current beat is channel beat*LANES+gi.
  assign ch_base = CH_W'(beat_q) * CH_W'(LANES);
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    assign lane_bus[gi*WIDTH +: WIDTH] = shadow_q[ch_base + CH_W'(gi)];
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (layer_sample) state_d = BURST;
      end
      BURST: begin
        if (beat_last) begin
          if (final_pix)          state_d = DONE;
          else if (layer_sample)  state_d = BURST;
          else                    state_d = IDLE;
        end
      end
      DONE:    state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath / output next values: counters, write port, feedback, overrun.
  always_comb begin
    beat_d    = beat_q;
    pixel_d   = pixel_q;
    addr_d    = addr_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    last_d    = 1'b0;
    fb_d      = last_q;
    overrun_d = overrun_q;
    shadow_d  = shadow_q;

    if (accept) shadow_d = ofm;

    case (state_q)
      IDLE: begin
        beat_d = '0;
      end
      BURST: begin
        wr_en_d   = 1'b1;
        wr_addr_d = addr_q;
        wr_data_d = lane_bus;
        addr_d    = addr_q + ADDR_W'(1);
        if (beat_last) begin
          beat_d  = '0;
          pixel_d = pixel_q + PIX_W'(1);
          last_d  = final_pix;
        end else begin
          beat_d  = beat_q + BEAT_W'(1);
          // Mid-burst sample cannot be held anywhere: drop and flag it.
          if (layer_sample) overrun_d = 1'b1;
        end
      end
      default: begin
        beat_d = beat_q;
      end
    endcase
  end

  // Control and write-port registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      beat_q    <= '0;
      pixel_q   <= '0;
      addr_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      last_q    <= 1'b0;
      fb_q      <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      beat_q    <= beat_d;
      pixel_q   <= pixel_d;
      addr_q    <= addr_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      last_q    <= last_d;
      fb_q      <= fb_d;
      overrun_q <= overrun_d;
    end
  end

  // Shadow vector holds the captured pixel; its contents need no reset.
  always_ff @(posedge clk) begin
    shadow_q <= shadow_d;
  end

  assign wr_en        = wr_en_q;
  assign wr_addr      = wr_addr_q;
  assign wr_data      = wr_data_q;
  assign ram_feedback = fb_q;
  assign busy         = (state_q == BURST);
  assign overrun      = overrun_q;

`ifdef OFM_WR_CHKSUM_EN
  logic [WIDTH-1:0] chksum_q, chksum_d;

  // Accumulate every lane word of the write currently on the port; after
  // the final write wr_en stays low, so the sum freezes in DONE.
  always_comb begin
    chksum_d = chksum_q;
    if (wr_en_q) begin
      for (int i = 0; i < LANES; i++) begin
        chksum_d = chksum_d + wr_data_q[i*WIDTH +: WIDTH];
      end
    end
  end

  // Checksum register.
  always_ff @(posedge clk) begin
    if (rst) chksum_q <= '0;
    else     chksum_q <= chksum_d;
  end

  assign chksum = chksum_q;
`endif

endmodule

// File: tb/tb_fire_ofm_writer.sv
// Directed bench for fire_ofm_writer at default parameters
// (DSP_NO=368, WIDTH=16, WOUT=8, LANES=4, BEATS=92).
// Inputs are driven and outputs sampled 1 time unit after the rising edge.
module tb_fire_ofm_writer;

  localparam int DSP_NO = 368;
  localparam int WIDTH  = 16;
  localparam int WOUT   = 8;
  localparam int LANES  = 4;
  localparam int ADDR_W = 13;

  logic                   clk;
  logic                   rst;
  logic                   layer_sample;
  logic [WIDTH-1:0]       ofm [DSP_NO];
  logic                   wr_en;
  logic [ADDR_W-1:0]      wr_addr;
  logic [LANES*WIDTH-1:0] wr_data;
  logic                   ram_feedback;
  logic                   busy;
  logic                   overrun;
`ifdef OFM_WR_CHKSUM_EN
  logic [WIDTH-1:0]       chksum;
`endif

  fire_ofm_writer #(
    .DSP_NO(DSP_NO), .WIDTH(WIDTH), .WOUT(WOUT), .LANES(LANES), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .layer_sample(layer_sample),
    .ofm(ofm),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .ram_feedback(ram_feedback),
    .busy(busy),
    .overrun(overrun)
`ifdef OFM_WR_CHKSUM_EN
    ,
    .chksum(chksum)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  // Free-running cycle counter and write-port monitor (sampled on negedge).
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic mon_clear = 1'b0;
  int   mon_writes, mon_next, mon_addr_err, mon_last_cyc, mon_last_addr;
  int   mon_fb_cnt, mon_fb_cyc;

  always @(negedge clk) begin
    if (mon_clear) begin
      mon_writes    = 0;
      mon_next      = 0;
      mon_addr_err  = 0;
      mon_last_cyc  = -1;
      mon_last_addr = -1;
      mon_fb_cnt    = 0;
      mon_fb_cyc    = -1;
    end else begin
      if (wr_en) begin
        mon_writes++;
        if (int'(wr_addr) != mon_next) mon_addr_err++;
        mon_next++;
        mon_last_cyc  = cyc;
        mon_last_addr = int'(wr_addr);
      end
      if (ram_feedback) begin
        mon_fb_cnt++;
        mon_fb_cyc = cyc;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tickn(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic pulse();
    layer_sample = 1'b1;
    tick();
    layer_sample = 1'b0;
  endtask

  task automatic set_ofm(input int base);
    for (int i = 0; i < DSP_NO; i++) ofm[i] = WIDTH'(base + i);
  endtask

  // Expected beat: channels c0..c0+3 with c0 in the low lane.
  function automatic logic [63:0] beat_word(input int c0);
    return {WIDTH'(c0 + 3), WIDTH'(c0 + 2), WIDTH'(c0 + 1), WIDTH'(c0)};
  endfunction

  int start_cyc;

  initial begin
    rst = 1'b1;
    layer_sample = 1'b0;
    set_ofm(0);
    tickn(3);
    chk("rst_wr_en", 64'(wr_en), 64'd0);
    chk("rst_wr_addr", 64'(wr_addr), 64'd0);
    chk("rst_wr_data", wr_data, 64'd0);
    chk("rst_feedback", 64'(ram_feedback), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_overrun", 64'(overrun), 64'd0);
`ifdef OFM_WR_CHKSUM_EN
    chk("rst_chksum", 64'(chksum), 64'd0);
`endif
    rst = 1'b0;

    // Single pixel, ofm[i]=i, sample in cycle 0.
    pulse();                                  // cycle 1
    chk("a_c1_wr_en", 64'(wr_en), 64'd0);
    chk("a_c1_busy", 64'(busy), 64'd1);
    tick();                                   // cycle 2
    chk("a_first_wr_en", 64'(wr_en), 64'd1);
    chk("a_first_addr", 64'(wr_addr), 64'd0);
    chk("a_first_data", wr_data, beat_word(0));
    tickn(91);                                // cycle 93
    chk("a_last_wr_en", 64'(wr_en), 64'd1);
    chk("a_last_addr", 64'(wr_addr), 64'd91);
    chk("a_last_data", wr_data, beat_word(364));
    tick();                                   // cycle 94
    chk("a_c94_wr_en", 64'(wr_en), 64'd0);
    chk("a_c94_busy", 64'(busy), 64'd0);
`ifdef OFM_WR_CHKSUM_EN
    chk("a_chksum", 64'(chksum), 64'd1992);   // 367*368/2 mod 65536
`endif
    $display("[TB] single pixel done");

    // Back-to-back: second sample on the beat=91 cycle.
    set_ofm(1000);
    pulse();                                  // cycle 1
    tickn(91);                                // cycle 92, beat 91
    set_ofm(2000);
    layer_sample = 1'b1;
    tick();                                   // cycle 93
    layer_sample = 1'b0;
    chk("b_last_addr", 64'(wr_addr), 64'd183);
    chk("b_last_data", wr_data, beat_word(1364));
    chk("b_busy", 64'(busy), 64'd1);
    tick();                                   // cycle 94
    chk("b_next_wr_en", 64'(wr_en), 64'd1);
    chk("b_next_addr", 64'(wr_addr), 64'd184);
    chk("b_next_data", wr_data, beat_word(2000));
    tickn(91);                                // cycle 185
    chk("b2_last_addr", 64'(wr_addr), 64'd275);
    tick();
    chk("b2_idle_wr_en", 64'(wr_en), 64'd0);
    $display("[TB] back-to-back done");

    // Overrun: extra sample at beat 10 is dropped.
    set_ofm(0);
    pulse();                                  // cycle 1
    tickn(10);                                // cycle 11, beat 10
    set_ofm(5000);
    layer_sample = 1'b1;
    tick();                                   // cycle 12
    layer_sample = 1'b0;
    chk("c_overrun", 64'(overrun), 64'd1);
    tick();                                   // cycle 13, beat 11 write
    chk("c_b11_addr", 64'(wr_addr), 64'd287);
    chk("c_b11_data", wr_data, beat_word(44));
    tickn(80);                                // cycle 93
    chk("c_last_addr", 64'(wr_addr), 64'd367);
    chk("c_last_data", wr_data, beat_word(364));
    tick();
    set_ofm(3000);
    pulse();                                  // cycle 1
    tick();                                   // cycle 2
    chk("c_next_addr", 64'(wr_addr), 64'd368);
    chk("c_next_data", wr_data, beat_word(3000));
    chk("c_overrun_sticky", 64'(overrun), 64'd1);
    tickn(92);
    $display("[TB] overrun done");

    // Reset mid-burst at beat 40.
    set_ofm(0);
    pulse();                                  // cycle 1
    tickn(40);                                // cycle 41
    rst = 1'b1;
    tick();                                   // cycle 42
    chk("r_wr_en", 64'(wr_en), 64'd0);
    chk("r_busy", 64'(busy), 64'd0);
    chk("r_overrun", 64'(overrun), 64'd0);
`ifdef OFM_WR_CHKSUM_EN
    chk("r_chksum", 64'(chksum), 64'd0);
`endif
    rst = 1'b0;
    mon_clear = 1'b1;
    tick();
    mon_clear = 1'b0;
    $display("[TB] mid-burst reset done");

    // Full map: 64 samples spaced 113 cycles.
    start_cyc = cyc;
    for (int p = 0; p < WOUT * WOUT; p++) begin
      set_ofm(p * 7);
      pulse();
      tickn(112);
    end
    chk("d_writes", 64'(mon_writes), 64'd5888);
    chk("d_addr_errs", 64'(mon_addr_err), 64'd0);
    chk("d_last_addr", 64'(mon_last_addr), 64'd5887);
    chk("d_fb_count", 64'(mon_fb_cnt), 64'd1);
    chk("d_fb_cycle", 64'(mon_fb_cyc - start_cyc), 64'd7213);
    chk("d_fb_after_last", 64'(mon_fb_cyc - mon_last_cyc), 64'd1);
    chk("d_overrun", 64'(overrun), 64'd0);
    $display("[TB] full map done");

    // Samples in DONE are ignored.
    for (int k = 0; k < 3; k++) begin
      pulse();
      tickn(20);
    end
    tickn(40);
    chk("e_writes", 64'(mon_writes), 64'd5888);
    chk("e_fb_count", 64'(mon_fb_cnt), 64'd1);
    chk("e_overrun", 64'(overrun), 64'd0);
    chk("e_busy", 64'(busy), 64'd0);
    chk("e_feedback", 64'(ram_feedback), 64'd0);
    $display("[TB] done-state samples done");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
